// File: rtl/mxpl_result_writer_if.sv
// Purpose: bundles the result-writer's control, input, SRAM-write and status
//          signals into one interface.
// Ports (signals):
//   start, in_valid, in_data, mem_grant      - driven by the upstream side (master)
//   mem_wr_en, mem_addr, mem_wdata           - SRAM write request from the writer
//   busy, layer_done, overflow               - writer status
// Modports: master = upstream/SRAM-arbiter side, slave = the result writer.
interface mxpl_result_writer_if #(
    parameter int unsigned DATAW = 20,
    parameter int unsigned ADDRW = 12
);
    logic             start;
    logic             in_valid;
    logic [DATAW-1:0] in_data;
    logic             mem_grant;
    logic             mem_wr_en;
    logic [ADDRW-1:0] mem_addr;
    logic [DATAW-1:0] mem_wdata;
    logic             busy;
    logic             layer_done;
    logic             overflow;

    modport master (
        output start, in_valid, in_data, mem_grant,
        input  mem_wr_en, mem_addr, mem_wdata, busy, layer_done, overflow
    );

    modport slave (
        input  start, in_valid, in_data, mem_grant,
        output mem_wr_en, mem_addr, mem_wdata, busy, layer_done, overflow
    );
endinterface

// File: rtl/mxpl_result_writer.sv
// Purpose: takes pooled results, applies optional ReLU, queues them in a small
//          FIFO and writes them to consecutive feature-map SRAM addresses,
//          holding each write until the shared port grants it. Counts results
//          per layer, pulses layer_done at the end, flags dropped inputs.
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous, active-high
//   bus    - mxpl_result_writer_if.slave (start/in_*/mem_grant in;
//            mem_wr_en/mem_addr/mem_wdata/busy/layer_done/overflow out)
module mxpl_result_writer #(
    parameter int unsigned     DATAW       = 20,
    parameter int unsigned     ADDRW       = 12,
    parameter int unsigned     FIFO_DEPTH  = 4,
    parameter logic [ADDRW-1:0] BASE_ADDR  = '0,
    parameter int unsigned     NUM_RESULTS = 1024,
    parameter bit              RELU_EN     = 1'b1
) (
    input logic                clk,
    input logic                reset,
    mxpl_result_writer_if.slave bus
);
    localparam int unsigned PTRW = $clog2(FIFO_DEPTH);
    localparam int unsigned CNTW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned ICW  = $clog2(NUM_RESULTS + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

    state_e           state_q, state_d;
    logic [DATAW-1:0] fifo_q [FIFO_DEPTH];
    logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]  count_q, count_d;
    logic [ICW-1:0]   in_cnt_q, in_cnt_d;
    logic [ADDRW-1:0] addr_q, addr_d;
    logic             ovf_q, ovf_d;
    logic             wr_en_q, wr_en_d;
    logic [ADDRW-1:0] mem_addr_q, mem_addr_d;
    logic [DATAW-1:0] wdata_q, wdata_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [DATAW-1:0] push_data;
    logic             full, pop, push, push_ok;

    // Input qualification: a full FIFO still accepts a push if it pops this cycle
    always_comb begin
        push_data = (RELU_EN && bus.in_data[DATAW-1]) ? '0 : bus.in_data;
        full      = (count_q == CNTW'(FIFO_DEPTH));
        pop       = wr_en_q && bus.mem_grant;
        push      = (state_q == S_RUN) && bus.in_valid;
        push_ok   = push && (!full || pop);
    end

    // Next-state, FIFO bookkeeping and registered-output precompute
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        in_cnt_d   = in_cnt_q;
        addr_d     = addr_q;
        ovf_d      = ovf_q;
        wr_en_d    = 1'b0;
        mem_addr_d = '0;
        wdata_d    = '0;
        busy_d     = 1'b0;
        done_d     = 1'b0;

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTRW'(1);
            addr_d   = addr_q + ADDRW'(1);
        end
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTRW'(1);
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d  = S_RUN;
                    addr_d   = BASE_ADDR;
                    in_cnt_d = '0;
                    ovf_d    = 1'b0;
                end
            end
            S_RUN: begin
                // Dropped inputs still count so the layer always terminates
                if (bus.in_valid) begin
                    in_cnt_d = in_cnt_q + ICW'(1);
                    if (!push_ok) begin
                        ovf_d = 1'b1;
                    end
                    if (in_cnt_d == ICW'(NUM_RESULTS)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (count_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        wr_en_d = ((state_d == S_RUN) || (state_d == S_DRAIN)) && (count_d != '0);
        if (wr_en_d) begin
            mem_addr_d = addr_d;
            // A single entry that was just pushed is not yet readable from storage
            wdata_d    = (push_ok && (count_d == CNTW'(1))) ? push_data : fifo_q[rd_ptr_d];
        end
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // FIFO storage; contents are don't-care while empty, so no reset
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_q[wr_ptr_q] <= push_data;
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            in_cnt_q   <= '0;
            addr_q     <= BASE_ADDR;
            ovf_q      <= 1'b0;
            wr_en_q    <= 1'b0;
            mem_addr_q <= '0;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            in_cnt_q   <= in_cnt_d;
            addr_q     <= addr_d;
            ovf_q      <= ovf_d;
            wr_en_q    <= wr_en_d;
            mem_addr_q <= mem_addr_d;
            wdata_q    <= wdata_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.mem_wr_en  = wr_en_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.busy       = busy_q;
    assign bus.layer_done = done_q;
    assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_mxpl_result_writer.sv
// Purpose: self-checking bench for mxpl_result_writer with a queue-based
//          reference model of the layer/FIFO/write rules.
// Ports: none (top-level bench).
module tb_mxpl_result_writer;
    localparam int unsigned DATAW = 20;
    localparam int unsigned ADDRW = 12;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned NUM   = 5;
    localparam logic [ADDRW-1:0] BASE = 12'hFFE;
    localparam int unsigned VW = ADDRW + DATAW + 4;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    int   done_pulses = 0;

    typedef struct {
        logic [ADDRW-1:0] a;
        logic [DATAW-1:0] d;
    } wr_t;
    wr_t obs_q[$];

    // Reference model: phase 0=idle 1=run 2=drain 3=done
    int               m_phase;
    logic [DATAW-1:0] m_q[$];
    logic [ADDRW-1:0] m_addr;
    int               m_cnt;
    bit               m_ovf;

    mxpl_result_writer_if #(.DATAW(DATAW), .ADDRW(ADDRW)) bus();

    mxpl_result_writer #(
        .DATAW(DATAW), .ADDRW(ADDRW), .FIFO_DEPTH(DEPTH),
        .BASE_ADDR(BASE), .NUM_RESULTS(NUM), .RELU_EN(1'b1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

    function automatic logic [DATAW-1:0] relu(input logic [DATAW-1:0] x);
        return x[DATAW-1] ? '0 : x;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_q.delete();
        m_addr = BASE;
        m_cnt = 0;
        m_ovf = 0;
    endtask

    task automatic model_step(input bit s, input bit v, input logic [DATAW-1:0] d, input bit g);
        bit writing;
        bit popped;
        int pre_size;
        pre_size = m_q.size();
        writing  = (m_phase == 1 || m_phase == 2) && (pre_size > 0);
        popped   = writing && g;
        if (popped) begin
            void'(m_q.pop_front());
            m_addr = m_addr + 1'b1;
        end
        case (m_phase)
            0: if (s) begin m_phase = 1; m_addr = BASE; m_cnt = 0; m_ovf = 0; end
            1: if (v) begin
                if (pre_size < int'(DEPTH) || popped) m_q.push_back(relu(d));
                else m_ovf = 1;
                m_cnt++;
                if (m_cnt == int'(NUM)) m_phase = 2;
            end
            2: if (pre_size == 0) m_phase = 3;
            default: m_phase = 0;
        endcase
    endtask

    function automatic logic [VW-1:0] exp_vec();
        bit w;
        logic [ADDRW-1:0] a;
        logic [DATAW-1:0] d;
        w = (m_phase == 1 || m_phase == 2) && (m_q.size() > 0);
        a = '0;
        d = '0;
        if (w) begin a = m_addr; d = m_q[0]; end
        return {w, a, d, m_phase != 0, m_phase == 3, m_ovf};
    endfunction

    // Address/data are only meaningful while a write is requested
    function automatic logic [VW-1:0] dut_vec();
        logic [ADDRW-1:0] a;
        logic [DATAW-1:0] d;
        a = bus.mem_wr_en ? bus.mem_addr : ADDRW'(0);
        d = bus.mem_wr_en ? bus.mem_wdata : DATAW'(0);
        return {bus.mem_wr_en, a, d, bus.busy, bus.layer_done, bus.overflow};
    endfunction

    // One clock: drive inputs, log a granted write, step model, sample #1 after edge
    task automatic tick(input bit s, input bit v, input logic [DATAW-1:0] d, input bit g);
        wr_t w;
        bus.start = s;
        bus.in_valid = v;
        bus.in_data = d;
        bus.mem_grant = g;
        #1;
        if (bus.mem_wr_en && g) begin
            w.a = bus.mem_addr;
            w.d = bus.mem_wdata;
            obs_q.push_back(w);
        end
        model_step(s, v, d, g);
        @(posedge clk);
        #1;
        if (bus.layer_done) done_pulses++;
    endtask

    task automatic test_reset();
        bus.start = 0; bus.in_valid = 0; bus.in_data = '0; bus.mem_grant = 0;
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.mem_wr_en, bus.mem_addr, bus.mem_wdata, bus.busy, bus.layer_done, bus.overflow} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {bus.mem_wr_en, bus.mem_addr, bus.mem_wdata, bus.busy, bus.layer_done, bus.overflow});
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [DATAW-1:0] din [NUM];
        logic [ADDRW-1:0] ea [NUM];
        logic [DATAW-1:0] ed [NUM];
        din = '{20'h00005, 20'hFFFFD, 20'h7FFFF, 20'h80000, 20'h00007};
        ea  = '{12'hFFE, 12'hFFF, 12'h000, 12'h001, 12'h002};
        ed  = '{20'h00005, 20'h00000, 20'h7FFFF, 20'h00000, 20'h00007};
        obs_q.delete();
        done_pulses = 0;
        tick(1, 0, '0, 1);
        for (int i = 0; i < int'(NUM); i++) begin
            tick(0, 1, din[i], 1);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL basic_cycle got=%h exp=%h", dut_vec(), exp_vec());
            end
        end
        for (int i = 0; i < 10; i++) begin
            tick(0, 0, '0, 1);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL basic_drain got=%h exp=%h", dut_vec(), exp_vec());
            end
        end
        checks++;
        if (obs_q.size() != int'(NUM)) begin
            failures++;
            $display("FAIL basic_write_count got=%0d exp=%0d", obs_q.size(), NUM);
        end else begin
            for (int i = 0; i < int'(NUM); i++) begin
                checks++;
                if (obs_q[i].a !== ea[i] || obs_q[i].d !== ed[i]) begin
                    failures++;
                    $display("FAIL basic_write%0d got=(%h,%h) exp=(%h,%h)", i, obs_q[i].a, obs_q[i].d, ea[i], ed[i]);
                end
            end
        end
        checks++;
        if (done_pulses != 1 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_done pulses=%0d busy=%b exp pulses=1 busy=0", done_pulses, bus.busy);
        end
    endtask

    task automatic test_overflow();
        logic [DATAW-1:0] din [NUM];
        obs_q.delete();
        done_pulses = 0;
        tick(1, 0, '0, 0);
        for (int i = 0; i < int'(NUM); i++) begin
            din[i] = DATAW'($urandom);
            tick(0, 1, din[i], 0);
        end
        checks++;
        if (bus.overflow !== 1'b1 || bus.mem_wr_en !== 1'b1) begin
            failures++;
            $display("FAIL ovf_flag got ovf=%b wr_en=%b exp 1 1", bus.overflow, bus.mem_wr_en);
        end
        for (int i = 0; i < 12; i++) begin
            tick(0, 0, '0, 1);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL ovf_drain got=%h exp=%h", dut_vec(), exp_vec());
            end
        end
        checks++;
        if (obs_q.size() != int'(DEPTH)) begin
            failures++;
            $display("FAIL ovf_write_count got=%0d exp=%0d", obs_q.size(), DEPTH);
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                checks++;
                if (obs_q[i].d !== relu(din[i]) || obs_q[i].a !== BASE + ADDRW'(i)) begin
                    failures++;
                    $display("FAIL ovf_write%0d got=(%h,%h) exp=(%h,%h)", i, obs_q[i].a, obs_q[i].d, BASE + ADDRW'(i), relu(din[i]));
                end
            end
        end
        checks++;
        if (done_pulses != 1 || bus.overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_done pulses=%0d ovf=%b exp pulses=1 ovf=1", done_pulses, bus.overflow);
        end
    endtask

    task automatic test_hold();
        logic [DATAW-1:0] d1;
        logic [ADDRW-1:0] sa;
        logic [DATAW-1:0] sd;
        done_pulses = 0;
        d1 = DATAW'($urandom_range(1, 20'h7FFFF));
        tick(1, 0, '0, 1);
        tick(0, 1, d1, 0);
        sa = bus.mem_addr;
        sd = bus.mem_wdata;
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, '0, 0);
            checks++;
            if (bus.mem_wr_en !== 1'b1 || bus.mem_addr !== sa || bus.mem_wdata !== sd ||
                sa !== BASE || sd !== d1 || bus.overflow !== 1'b0) begin
                failures++;
                $display("FAIL hold_cycle%0d got wr=%b a=%h d=%h ovf=%b exp wr=1 a=%h d=%h ovf=0",
                         i, bus.mem_wr_en, bus.mem_addr, bus.mem_wdata, bus.overflow, BASE, d1);
            end
        end
        for (int i = 0; i < int'(NUM) - 1; i++) tick(0, 1, DATAW'($urandom), 1);
        for (int i = 0; i < 10; i++) begin
            tick(0, 0, '0, 1);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL hold_drain got=%h exp=%h", dut_vec(), exp_vec());
            end
        end
        checks++;
        if (done_pulses != 1) begin
            failures++;
            $display("FAIL hold_done pulses=%0d exp=1", done_pulses);
        end
    endtask

    task automatic test_reset_mid();
        logic [DATAW-1:0] d1;
        obs_q.delete();
        done_pulses = 0;
        tick(1, 0, '0, 0);
        for (int i = 0; i < int'(NUM); i++) tick(0, 1, DATAW'($urandom), 0);
        tick(0, 0, '0, 1);
        tick(0, 0, '0, 1);
        checks++;
        if (obs_q.size() != 2 || bus.overflow !== 1'b1 || bus.mem_wr_en !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pre writes=%0d ovf=%b wr=%b exp 2 1 1", obs_q.size(), bus.overflow, bus.mem_wr_en);
        end
        reset = 1'b1;
        model_reset();
        #2;
        checks++;
        if ({bus.mem_wr_en, bus.mem_addr, bus.mem_wdata, bus.busy, bus.layer_done, bus.overflow} !== '0) begin
            failures++;
            $display("FAIL rstmid_outputs got=%h exp=0",
                     {bus.mem_wr_en, bus.mem_addr, bus.mem_wdata, bus.busy, bus.layer_done, bus.overflow});
        end
        reset = 1'b0;
        d1 = DATAW'($urandom);
        tick(1, 0, '0, 1);
        tick(0, 1, d1, 1);
        checks++;
        if (bus.mem_wr_en !== 1'b1 || bus.mem_addr !== BASE || bus.mem_wdata !== relu(d1) || bus.overflow !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_restart got wr=%b a=%h d=%h ovf=%b exp wr=1 a=%h d=%h ovf=0",
                     bus.mem_wr_en, bus.mem_addr, bus.mem_wdata, bus.overflow, BASE, relu(d1));
        end
        for (int i = 0; i < int'(NUM) - 1; i++) tick(0, 1, DATAW'($urandom), 1);
        for (int i = 0; i < 10; i++) begin
            tick(0, 0, '0, 1);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL rstmid_drain got=%h exp=%h", dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_ignore();
        obs_q.delete();
        done_pulses = 0;
        for (int i = 0; i < 3; i++) tick(0, 1, DATAW'($urandom), 1);
        checks++;
        if (bus.busy !== 1'b0 || bus.mem_wr_en !== 1'b0 || obs_q.size() != 0) begin
            failures++;
            $display("FAIL ign_idle got busy=%b wr=%b writes=%0d exp 0 0 0", bus.busy, bus.mem_wr_en, obs_q.size());
        end
        tick(1, 0, '0, 0);
        tick(0, 1, DATAW'($urandom), 0);
        tick(1, 1, DATAW'($urandom), 0);
        tick(0, 1, DATAW'($urandom), 0);
        tick(0, 1, DATAW'($urandom), 0);
        tick(0, 1, DATAW'($urandom), 1);
        checks++;
        if (bus.overflow !== 1'b0 || dut_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL ign_pushpop got=%h exp=%h", dut_vec(), exp_vec());
        end
        for (int i = 0; i < 12; i++) begin
            tick(0, 0, '0, 1);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL ign_drain got=%h exp=%h", dut_vec(), exp_vec());
            end
        end
        checks++;
        if (obs_q.size() != int'(NUM) || done_pulses != 1) begin
            failures++;
            $display("FAIL ign_layer writes=%0d pulses=%0d exp %0d 1", obs_q.size(), done_pulses, NUM);
        end
    endtask

    task automatic test_random();
        bit s, v, g;
        done_pulses = 0;
        for (int i = 0; i < 1500; i++) begin
            s = ($urandom_range(0, 7) == 0);
            v = ($urandom_range(0, 2) != 0);
            g = ($urandom_range(0, 3) != 0);
            tick(s, v, DATAW'($urandom), g);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL rand_cycle%0d got=%h exp=%h", i, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (done_pulses < 10) begin
            failures++;
            $display("FAIL rand_layers got=%0d exp>=10", done_pulses);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_hold();
        test_reset_mid();
        test_ignore();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
